mem_channel_arbiter: RTL and testbench
======================================

MEM_CHANNEL_ARBITER -- requirements
Module: mem_channel_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, SHALL be the per-channel byte address width.
REQ-002 Parameter DATA_W, default 8, SHALL be the per-channel data width.
REQ-003 Parameter READ_LAT, default 2, SHALL be the memory read latency in cycles, legal range 1..8.
REQ-004 Parameter WRITE_LAT, default 1, SHALL be the write completion latency in cycles, legal range 1..8.
REQ-005 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-006 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 req_oe  in  2  per-channel read request; channel c uses bit c.
REQ-009 req_we  in  2  per-channel write request.
REQ-010 req_addr  in  2*ADDR_W  per-channel address; channel c uses slice [c*ADDR_W +: ADDR_W].
REQ-011 req_wdata  in  2*DATA_W  per-channel write data.
REQ-012 req_size  in  8  per-channel access size in bits; channel c uses [c*4 +: 4].
REQ-013 req_rdata  out  2*DATA_W  per-channel read data.
REQ-014 req_rdy  out  2  per-channel one-cycle completion pulse.
REQ-015 mem_oe, mem_we  out  1 each  single-port memory strobes.
REQ-016 mem_addr  out  ADDR_W  memory address.
REQ-017 mem_wdata  out  DATA_W  memory write data.
REQ-018 mem_mask  out  DATA_W  memory write bit mask.
REQ-019 mem_rdata  in  DATA_W  memory read data, valid READ_LAT cycles after the mem_oe cycle.
REQ-020 err  out  1  sticky protocol error flag.

Function
REQ-021 A requester SHALL hold oe/we, addr, wdata and size stable until it samples its req_rdy; it SHALL deassert them on the following cycle.
REQ-022 The FSM SHALL use states IDLE, RD_WAIT and WR_WAIT.
REQ-023 IDLE with any request: the arbiter SHALL grant one channel, register its fields, and go to RD_WAIT (oe) or WR_WAIT (we).
REQ-024 Grant SHALL be round-robin: when both channels request, the pointer channel wins; after every grant the pointer SHALL move to the other channel.
REQ-025 For a request in IDLE at cycle T, mem_oe or mem_we SHALL be high for exactly cycle T+1, with mem_addr, mem_wdata and mem_mask driven from the registered fields.
REQ-026 Read: in cycle T+1+READ_LAT, req_rdy[c] SHALL pulse and req_rdata slice c SHALL carry mem_rdata; the FSM SHALL return to IDLE.
REQ-027 Write: req_rdy[c] SHALL pulse in cycle T+WRITE_LAT (no earlier than T+1); the FSM SHALL return to IDLE.
REQ-028 mem_mask SHALL equal (1<<size)-1 computed in 9 bits and truncated to DATA_W; size>=DATA_W SHALL give all ones.
REQ-029 A non-granted channel SHALL wait with req_rdy low; its request SHALL be served next, so starvation is bounded to one transaction.
REQ-030 Requests arriving outside IDLE SHALL NOT be sampled until IDLE.
REQ-031 req_rdata slice c SHALL hold its last value until the next read completion on channel c.
REQ-032 A channel with oe and we both high SHALL be treated as a read.

Reset
REQ-033 Reset low SHALL immediately force IDLE, pointer=0, and mem_oe, mem_we, mem_addr, mem_wdata, mem_mask, req_rdy, req_rdata and err all to 0.
REQ-034 A transaction in flight at reset SHALL be dropped; no req_rdy pulse SHALL follow.

Configuration
REQ-035 With MEM_ARB_PROTOCOL_CHECK_EN defined, err SHALL set when any channel has oe and we both high, or changes addr while pending; err SHALL clear only on reset.
REQ-036 Without MEM_ARB_PROTOCOL_CHECK_EN, err SHALL be tied to 0 and the checker logic SHALL be absent.

Structure
REQ-037 The FSM state enum, the default latency constants and the mask function SHALL live in shared package mem_arb_pkg.
REQ-038 The round-robin selector SHALL be sub-module rr_arb2 (inputs: 2 requests, advance; output: one-hot grant).

Verification
REQ-039 Ch0 read addr 0x05 with the memory returning 0xA5, READ_LAT=2 -> mem_oe high at T+1; req_rdy[0] and rdata0=0xA5 at T+3.
REQ-040 Both channels write in the same cycle after reset -> ch0 is served first with rdy at T+1; ch1 is served next; pointer is back to 0.
REQ-041 Ch1 write with size=4 and wdata 0xFF -> mem_mask=0x0F; size=8 -> mask=0xFF.
REQ-042 Reset asserted during RD_WAIT -> all outputs 0 at once; no req_rdy afterwards; the next request is served normally.
REQ-043 Check enabled, ch0 drives oe=we=1 -> err=1 sticky and the request is served as a read; check disabled -> err stays 0.
REQ-044 Ch0 holds a request back-to-back while ch1 is idle -> each transaction is served; ch1 request raised mid-transaction is granted next.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, latency defaults and write-mask helper for mem_channel_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } arb_state_t;

    localparam int DEF_READ_LAT  = 2;
    localparam int DEF_WRITE_LAT = 1;

    // (1<<size)-1 evaluated in 9 bits; sizes at or beyond the data width
    // select every bit. Callers cast the result down to their data width.
    function automatic logic [31:0] size_mask(input logic [3:0] size, input int data_w);
        logic [8:0] m9;
        m9 = (9'd1 << size) - 9'd1;
        if (int'(size) >= data_w) begin
            size_mask = '1;
        end else begin
            size_mask = {23'd0, m9};
        end
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin selector with one-hot grant
// Ports: clock, reset (async active-low); req[1:0] requests; advance commits the
//        current grant and moves the pointer away from the winner; grant[1:0] one-hot.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    // The pointer only matters on a tie; a lone requester always wins.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

    // Pointing at the loser (not merely toggling) bounds starvation to one
    // transaction even when the same channel wins several times alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (advance && (|grant)) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/mem_channel_arbiter.sv
// rtl/mem_channel_arbiter.sv - two-channel round-robin arbiter onto one single-port memory
// Optional feature: define MEM_ARB_PROTOCOL_CHECK_EN for the sticky requester-protocol err flag.
// Ports: clock; reset (async active-low);
//        req_oe/req_we/req_addr/req_wdata/req_size  per-channel request fields (channel c = slice c);
//        req_rdata/req_rdy                           per-channel read data and completion pulse;
//        mem_oe/mem_we/mem_addr/mem_wdata/mem_mask   memory strobes and registered fields;
//        mem_rdata                                   memory data, valid READ_LAT cycles after mem_oe;
//        err                                         sticky protocol error.
module mem_channel_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 8,
    parameter int READ_LAT  = DEF_READ_LAT,
    parameter int WRITE_LAT = DEF_WRITE_LAT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            req_oe,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    input  logic [7:0]            req_size,
    output logic [2*DATA_W-1:0]   req_rdata,
    output logic [1:0]            req_rdy,
    output logic                  mem_oe,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_mask,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  err
);

    // cnt is 0 in the strobe cycle, so a read completes when cnt reaches
    // READ_LAT and a write completes WRITE_LAT-1 cycles after its strobe.
    localparam logic [3:0] RD_LAST = 4'(READ_LAT);
    localparam logic [3:0] WR_LAST = 4'(WRITE_LAT - 1);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [3:0]          cnt;
    logic                ch_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   mask_q;
    logic [2*DATA_W-1:0] rdata_q;

    logic [1:0]          req_any;
    logic [1:0]          grant;
    logic                idle_take;
    logic                gch;
    logic                g_rd;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_wdata;
    logic [3:0]          g_size;
    logic                rd_done;
    logic                wr_done;

    assign req_any   = req_oe | req_we;
    assign idle_take = (state == IDLE) && (|req_any);

    rr_arb2 u_rr (
        .clock   (clock),
        .reset   (reset),
        .req     (req_any),
        .advance (idle_take),
        .grant   (grant)
    );

    // oe takes precedence, so a channel driving oe and we together reads.
    assign gch     = grant[1];
    assign g_rd    = |(grant & req_oe);
    assign g_addr  = gch ? req_addr[ADDR_W +: ADDR_W]   : req_addr[0 +: ADDR_W];
    assign g_wdata = gch ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
    assign g_size  = gch ? req_size[7:4]               : req_size[3:0];

    assign rd_done = (state == RD_WAIT) && (cnt == RD_LAST);
    assign wr_done = (state == WR_WAIT) && (cnt == WR_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_oe    = (state == RD_WAIT) && (cnt == 4'd0);
        mem_we    = (state == WR_WAIT) && (cnt == 4'd0);
        req_rdy   = 2'b00;
        req_rdata = rdata_q;
        case (state)
            IDLE:    if (idle_take) state_nxt = g_rd ? RD_WAIT : WR_WAIT;
            RD_WAIT: if (rd_done)   state_nxt = IDLE;
            WR_WAIT: if (wr_done)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (rd_done || wr_done) begin
            req_rdy = ch_q ? 2'b10 : 2'b01;
        end
        // Memory data is only valid in the completion cycle itself, so it is
        // forwarded combinationally and captured into the hold register.
        if (rd_done) begin
            if (ch_q) begin
                req_rdata[DATA_W +: DATA_W] = mem_rdata;
            end else begin
                req_rdata[0 +: DATA_W] = mem_rdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            ch_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (idle_take) begin
                cnt     <= '0;
                ch_q    <= gch;
                addr_q  <= g_addr;
                wdata_q <= g_wdata;
                mask_q  <= DATA_W'(size_mask(g_size, DATA_W));
            end else if (state != IDLE) begin
                cnt <= cnt + 4'd1;
            end
            if (rd_done) begin
                if (ch_q) begin
                    rdata_q[DATA_W +: DATA_W] <= mem_rdata;
                end else begin
                    rdata_q[0 +: DATA_W] <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_mask  = mask_q;

`ifdef MEM_ARB_PROTOCOL_CHECK_EN
    logic                err_q;
    logic [1:0]          pend_q;
    logic [2*ADDR_W-1:0] addr_prev;
    logic [1:0]          addr_moved;

    // A channel is pending from the cycle it raises a request until the
    // cycle its req_rdy is seen; its address must not move in between.
    always_comb begin
        addr_moved[0] = pend_q[0] && req_any[0] &&
                        (req_addr[0 +: ADDR_W] != addr_prev[0 +: ADDR_W]);
        addr_moved[1] = pend_q[1] && req_any[1] &&
                        (req_addr[ADDR_W +: ADDR_W] != addr_prev[ADDR_W +: ADDR_W]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q     <= 1'b0;
            pend_q    <= 2'b00;
            addr_prev <= '0;
        end else begin
            err_q     <= err_q | (|(req_oe & req_we)) | (|addr_moved);
            pend_q    <= req_any & ~req_rdy;
            addr_prev <= req_addr;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// tb/tb_mem_channel_arbiter.sv - randomized self-checking bench for mem_channel_arbiter
module tb_mem_channel_arbiter;

    localparam int AW  = 7;
    localparam int DW  = 8;
    localparam int RL  = 2;
    localparam int WL  = 1;
    localparam int NS  = 64;
    localparam int WAIT_BOUND = 2 * ((RL > WL) ? RL : WL) + 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [1:0]      req_oe, req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [7:0]      req_size;
    logic [2*DW-1:0] req_rdata;
    logic [1:0]      req_rdy;
    logic            mem_oe, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_mask, mem_rdata;
    logic            err;

    mem_channel_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
        .clock(clock), .reset(reset),
        .req_oe(req_oe), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_rdata(req_rdata), .req_rdy(req_rdy),
        .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_mask(mem_mask), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // requester state
    bit            active[2], seen[2], queued[2], rand_en;
    int            gap[2], wait_len[2];
    bit            q_oe[2], q_we[2];
    logic [AW-1:0] q_addr[2];
    logic [DW-1:0] q_wdata[2];
    logic [3:0]    q_size[2];

    // memory environment and reference model
    logic [DW-1:0] env_mem[128], model_mem[128];
    logic [DW-1:0] rp[NS];
    bit            rv[NS];
    bit            e_oe[NS], e_we[NS], e_isrd[NS];
    logic [1:0]    e_rdy[NS];
    logic [AW-1:0] e_addr[NS];
    logic [DW-1:0] e_wd[NS], e_mk[NS], e_rdval[NS];
    logic [DW-1:0] hold_m[2];
    int            ptr_m, free_at;
    bit            err_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int c, input bit oe, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] sz);
        req_oe[c] = oe;
        req_we[c] = we;
        req_addr[c*AW +: AW]  = a;
        req_wdata[c*DW +: DW] = d;
        req_size[c*4 +: 4]    = sz;
    endtask

    task automatic issue(input int c, input bit oe, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] sz);
        q_oe[c] = oe; q_we[c] = we; q_addr[c] = a; q_wdata[c] = d; q_size[c] = sz;
        queued[c] = 1'b1;
    endtask

    task automatic wait_neg(input int k);
        do @(negedge clock); while (cyc < k);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((active[0] || active[1] || queued[0] || queued[1]) && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("idle_timeout", (n < 200), 1'b1);
    endtask

    // requester driver: holds a request until its rdy was sampled, then drops it for a cycle
    initial begin
        req_oe = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_size = '0;
        forever begin
            @(posedge clock);
            #1;
            for (int c = 0; c < 2; c++) begin
                if (!reset) begin
                    drive(c, 0, 0, '0, '0, '0);
                    active[c] = 1'b0;
                    seen[c]   = 1'b0;
                end else if (active[c]) begin
                    if (seen[c]) begin
                        drive(c, 0, 0, '0, '0, '0);
                        active[c] = 1'b0;
                        seen[c]   = 1'b0;
                        gap[c]    = $urandom_range(0, 3);
                    end
                end else if (queued[c]) begin
                    drive(c, q_oe[c], q_we[c], q_addr[c], q_wdata[c], q_size[c]);
                    queued[c]   = 1'b0;
                    active[c]   = 1'b1;
                    wait_len[c] = 0;
                end else if (rand_en) begin
                    if (gap[c] > 0) begin
                        gap[c]--;
                    end else begin
                        int k;
                        k = $urandom_range(0, 9);
                        drive(c, (k <= 4), (k == 0 || k >= 5), AW'($urandom_range(0, 15)),
                              DW'($urandom), 4'($urandom_range(0, 15)));
                        active[c]   = 1'b1;
                        wait_len[c] = 0;
                    end
                end
            end
        end
    end

    // memory environment: applies masked writes, returns read data READ_LAT cycles after mem_oe
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                for (int i = 0; i < NS; i++) rv[i] = 1'b0;
            end else begin
                if (mem_we)
                    env_mem[mem_addr] = (env_mem[mem_addr] & ~mem_mask) | (mem_wdata & mem_mask);
                if (mem_oe) begin
                    rp[(cyc + RL) % NS] = env_mem[mem_addr];
                    rv[(cyc + RL) % NS] = 1'b1;
                end
            end
        end
    end

    initial begin
        mem_rdata = '0;
        forever begin
            int s;
            @(posedge clock);
            #1;
            s = cyc % NS;
            if (rv[s]) begin
                mem_rdata = rp[s];
                rv[s] = 1'b0;
            end else begin
                mem_rdata = DW'($urandom);
            end
        end
    end

    // compare process: checks outputs against the transaction-level model, then advances it
    initial begin
        forever begin
            int s, s1, w, done_c;
            bit r0, r1, rd;
            logic [AW-1:0] a;
            logic [DW-1:0] d, mk;
            int sz;
            @(negedge clock);
            if (!reset) begin
                chk("rst_rdy", req_rdy, 2'b00);
                chk("rst_rdata", req_rdata, '0);
                chk("rst_strobes", {mem_oe, mem_we}, 2'b00);
                chk("rst_fields", {mem_addr, mem_wdata, mem_mask}, '0);
                chk("rst_err", err, 1'b0);
                for (int i = 0; i < NS; i++) begin
                    e_oe[i] = 0; e_we[i] = 0; e_isrd[i] = 0; e_rdy[i] = '0;
                end
                hold_m[0] = '0; hold_m[1] = '0;
                ptr_m = 0; err_m = 0; free_at = cyc + 1;
                seen[0] = 0; seen[1] = 0;
            end else begin
                s = cyc % NS;
                for (int c = 0; c < 2; c++)
                    if (e_rdy[s][c] && e_isrd[s]) hold_m[c] = e_rdval[s];
                chk("req_rdy", req_rdy, e_rdy[s]);
                chk("req_rdata", req_rdata, {hold_m[1], hold_m[0]});
                chk("mem_strobes", {mem_oe, mem_we}, {e_oe[s], e_we[s]});
                if (e_oe[s] || e_we[s]) chk("mem_addr", mem_addr, e_addr[s]);
                if (e_we[s]) chk("mem_wdata_mask", {mem_wdata, mem_mask}, {e_wd[s], e_mk[s]});
                chk("err", err, err_m);
                for (int c = 0; c < 2; c++) begin
                    if (active[c]) wait_len[c]++;
                    if (active[c] && req_rdy[c]) begin
                        seen[c] = 1'b1;
                        chk("wait_bound", (wait_len[c] <= WAIT_BOUND), 1'b1);
                    end
                end
                e_oe[s] = 0; e_we[s] = 0; e_isrd[s] = 0; e_rdy[s] = '0;
`ifdef MEM_ARB_PROTOCOL_CHECK_EN
                if (|(req_oe & req_we)) err_m = 1'b1;
`endif
                r0 = req_oe[0] | req_we[0];
                r1 = req_oe[1] | req_we[1];
                if (cyc >= free_at && (r0 || r1)) begin
                    w = (r0 && r1) ? ptr_m : (r1 ? 1 : 0);
                    ptr_m = 1 - w;
                    rd = req_oe[w];
                    a  = req_addr[w*AW +: AW];
                    d  = req_wdata[w*DW +: DW];
                    sz = int'(req_size[w*4 +: 4]);
                    mk = (sz >= DW) ? {DW{1'b1}} : DW'((1 << sz) - 1);
                    s1 = (cyc + 1) % NS;
                    e_oe[s1] = rd; e_we[s1] = !rd; e_addr[s1] = a; e_wd[s1] = d; e_mk[s1] = mk;
                    if (rd) begin
                        done_c = cyc + 1 + RL;
                        e_rdval[done_c % NS] = model_mem[a];
                        e_isrd[done_c % NS]  = 1'b1;
                    end else begin
                        done_c = cyc + WL;
                        model_mem[a] = (model_mem[a] & ~mk) | (d & mk);
                    end
                    e_rdy[done_c % NS][w] = 1'b1;
                    free_at = done_c + 1;
                end
            end
        end
    end

    initial begin
        int t;
        logic [DW-1:0] v;
        reset = 1'b0;
        rand_en = 1'b0;
        for (int i = 0; i < 128; i++) begin
            v = DW'($urandom);
            env_mem[i] = v;
            model_mem[i] = v;
        end
        env_mem[5] = 8'hA5;
        model_mem[5] = 8'hA5;
        repeat (3) @(negedge clock);
        chk("reset_outputs", {req_rdy, req_rdata, mem_oe, mem_we, mem_mask, err}, '0);
        #2 reset = 1'b1;

        // both channels write together right after reset: ch0 first, then ch1
        issue(0, 0, 1, 7'h10, 8'h3C, 4'd8);
        issue(1, 0, 1, 7'h11, 8'hFF, 4'd4);
        @(posedge clock); #2 t = cyc;
        wait_neg(t + 1);
        chk("dual_wr_rdy0", req_rdy, 2'b01);
        chk("dual_wr_ch0_mem", {mem_we, mem_addr, mem_wdata, mem_mask}, {1'b1, 7'h10, 8'h3C, 8'hFF});
        wait_neg(t + 3);
        chk("dual_wr_rdy1", req_rdy, 2'b10);
        chk("dual_wr_ch1_mem", {mem_we, mem_addr, mem_wdata, mem_mask}, {1'b1, 7'h11, 8'hFF, 8'h0F});
        wait_idle();

        // pointer is back on ch0: a tie goes to ch0 again
        issue(0, 1, 0, 7'h10, 8'h00, 4'd8);
        issue(1, 1, 0, 7'h11, 8'h00, 4'd8);
        @(posedge clock); #2 t = cyc;
        wait_neg(t + 1);
        chk("tie_ptr0_addr", {mem_oe, mem_addr}, {1'b1, 7'h10});
        wait_neg(t + 3);
        chk("tie_rd_ch0", {req_rdy, req_rdata[7:0]}, {2'b01, 8'h3C});
        wait_idle();

        // single ch0 read of address 5 returning 0xA5
        issue(0, 1, 0, 7'h05, 8'h00, 4'd8);
        @(posedge clock); #2 t = cyc;
        wait_neg(t + 1);
        chk("rd5_strobe", {mem_oe, mem_we, mem_addr}, {1'b1, 1'b0, 7'h05});
        wait_neg(t + 2);
        chk("rd5_not_yet", req_rdy, 2'b00);
        wait_neg(t + 3);
        chk("rd5_done", {req_rdy, req_rdata[7:0]}, {2'b01, 8'hA5});
        wait_idle();

        // oe and we together on ch0 is served as a read
        issue(0, 1, 1, 7'h05, 8'h5A, 4'd8);
        @(posedge clock); #2 t = cyc;
        wait_neg(t + 1);
        chk("oe_we_is_read", {mem_oe, mem_we}, 2'b10);
`ifdef MEM_ARB_PROTOCOL_CHECK_EN
        chk("oe_we_err", err, 1'b1);
`else
        chk("oe_we_err", err, 1'b0);
`endif
        wait_neg(t + 3);
        chk("oe_we_rdata", {req_rdy, req_rdata[7:0]}, {2'b01, 8'hA5});
        wait_idle();

        rand_en = 1'b1;
        repeat (2500) @(posedge clock);
        rand_en = 1'b0;
        wait_idle();

        // reset while a read is outstanding
        issue(0, 1, 0, 7'h05, 8'h00, 4'd8);
        @(posedge clock); #2 t = cyc;
        wait_neg(t + 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_outputs", {req_rdy, req_rdata, mem_oe, mem_we, mem_addr, mem_wdata, mem_mask, err}, '0);
        @(negedge clock);
        #2 reset = 1'b1;
        repeat (6) begin
            @(negedge clock);
            chk("midrst_no_rdy", req_rdy, 2'b00);
        end
        wait_idle();
        v = model_mem[5];
        issue(1, 1, 0, 7'h05, 8'h00, 4'd8);
        @(posedge clock); #2 t = cyc;
        wait_neg(t + 3);
        chk("post_rst_read", {req_rdy, req_rdata}, {2'b10, v, 8'h00});
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
